serial_frame_rx: RTL and testbench

Downstream consumer of the 4-bit shift register's serial output. Samples one bit per enabled clock, hunts for a 4-bit sync nibble, then assembles the next two nibbles into a byte, checks an optional even-parity bit, and delivers accepted bytes through a 2-entry buffered valid/ready interface. Feeds the byte-level logic that follows the shift stage.

---
 rtl/serial_frame_rx.sv | 159 +++++++++++++++
 tb/tb_serial_frame_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync nibble, assembles a byte from the next two
// nibbles, optionally checks even parity, and queues accepted bytes in a 2-entry FIFO.
module serial_frame_rx #(
    parameter logic [3:0] SYNC      = 4'b1010,
    parameter bit         PARITY_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       s_in,
    input  logic       dir,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       par_err,
    output logic       overflow,
    output logic       busy
);

    typedef enum logic [1:0] {HUNT, DATA_HI, DATA_LO, PAR} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  sh_reg, sh_next, sh_shift;
    logic [2:0]  hunt_cnt_reg, hunt_cnt_next;
    logic [1:0]  bit_cnt_reg, bit_cnt_next;
    logic        dir_f_reg, dir_f_next;
    logic [7:0]  byte_reg, byte_next;
    logic        shift_dir;
    logic        frame_done, frame_good;

    logic [7:0]  mem_reg [2];
    logic        wr_ptr_reg, rd_ptr_reg;
    logic [1:0]  count_reg, count_next;
    logic        push, pop, drop;
    logic        par_err_reg, overflow_reg;

    // Hunting follows the live dir input; a frame in progress uses the latched order.
    assign shift_dir = (state_reg == HUNT) ? dir : dir_f_reg;
    assign sh_shift  = shift_dir ? {s_in, sh_reg[3:1]} : {sh_reg[2:0], s_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= HUNT;
            sh_reg       <= 4'h0;
            hunt_cnt_reg <= 3'd0;
            bit_cnt_reg  <= 2'd0;
            dir_f_reg    <= 1'b0;
            byte_reg     <= 8'h00;
        end else begin
            state_reg    <= state_next;
            sh_reg       <= sh_next;
            hunt_cnt_reg <= hunt_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            dir_f_reg    <= dir_f_next;
            byte_reg     <= byte_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sh_next       = sh_reg;
        hunt_cnt_next = hunt_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        dir_f_next    = dir_f_reg;
        byte_next     = byte_reg;
        frame_done    = 1'b0;
        frame_good    = 1'b0;
        if (enb) begin
            sh_next = sh_shift;
            case (state_reg)
                HUNT: begin
                    if (hunt_cnt_reg != 3'd4) begin
                        hunt_cnt_next = hunt_cnt_reg + 3'd1;
                    end
                    if (sh_shift == SYNC && hunt_cnt_reg >= 3'd3) begin
                        state_next   = DATA_HI;
                        bit_cnt_next = 2'd0;
                        dir_f_next   = dir;
                    end
                end
                DATA_HI: begin
                    bit_cnt_next = bit_cnt_reg + 2'd1;
                    if (bit_cnt_reg == 2'd3) begin
                        byte_next[7:4] = sh_shift;
                        state_next     = DATA_LO;
                    end
                end
                DATA_LO: begin
                    bit_cnt_next = bit_cnt_reg + 2'd1;
                    if (bit_cnt_reg == 2'd3) begin
                        byte_next[3:0] = sh_shift;
                        if (PARITY_EN) begin
                            state_next = PAR;
                        end else begin
                            state_next    = HUNT;
                            hunt_cnt_next = 3'd0;
                            frame_done    = 1'b1;
                            frame_good    = 1'b1;
                        end
                    end
                end
                PAR: begin
                    state_next    = HUNT;
                    hunt_cnt_next = 3'd0;
                    frame_done    = 1'b1;
                    frame_good    = ~(^{byte_reg, s_in});
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // A full buffer still accepts a byte when the head leaves in the same cycle.
    assign pop  = (count_reg != 2'd0) && out_ready;
    assign push = frame_good && ((count_reg != 2'd2) || pop);
    assign drop = frame_good && !push;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= byte_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            par_err_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg    <= count_next;
            par_err_reg  <= frame_done && !frame_good;
            overflow_reg <= drop;
        end
    end

    assign out_valid = (count_reg != 2'd0);
    assign out_data  = out_valid ? mem_reg[rd_ptr_reg] : 8'h00;
    assign par_err   = par_err_reg;
    assign overflow  = overflow_reg;
    assign busy      = (state_reg != HUNT);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx; expected bytes are queued when a frame is sent
// and compared when the receiver presents them.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b0;
    logic       s_in = 1'b0;
    logic       dir = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       par_err;
    logic       overflow;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb[$];

    serial_frame_rx dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .s_in      (s_in),
        .dir       (dir),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .par_err   (par_err),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        s_in = b;
        enb  = 1'b1;
        tick();
        if (gap > 0) begin
            enb = 1'b0;
            repeat (gap) tick();
        end
    endtask

    // Sends sync, byte and (optionally corrupted) even parity in the order chosen by d.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit d,
                              input bit flip_dir, input int gap_max);
        logic [3:0] sync_v;
        int idx;
        sync_v = 4'b1010;
        dir = d;
        for (int i = 0; i < 4; i++) begin
            send_bit(d ? sync_v[i] : sync_v[3-i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        check("busy_after_sync", busy, 1);
        if (flip_dir) dir = ~d;
        for (int i = 0; i < 8; i++) begin
            if (!d) idx = 7 - i;
            else    idx = (i < 4) ? 4 + i : i - 4;
            send_bit(b[idx], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
        send_bit((^b) ^ bad_par, 0);
        enb = 1'b0;
        check("busy_after_frame", busy, 0);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        check({tag, "_valid"}, out_valid, 1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_queue: observed empty scoreboard expected entry", tag);
        end else begin
            exp = sb.pop_front();
            check({tag, "_data"}, out_data, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset with random line activity
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_in = 1'($urandom);
            enb  = 1'($urandom);
            tick();
            check("rst_valid", out_valid, 0);
            check("rst_data", out_data, 8'h00);
            check("rst_par_err", par_err, 0);
            check("rst_overflow", overflow, 0);
            check("rst_busy", busy, 0);
        end
        rst = 1'b0;
        enb = 1'b0;
        tick();

        // MSB-first frame 0x35
        sb.push_back(8'h35);
        send_frame(8'h35, 1'b0, 1'b0, 1'b0, 0);
        check("f35_par_err", par_err, 0);
        pop_check("f35");
        check("f35_empty", out_valid, 0);

        // LSB-first frame 0xC3 with dir flipped mid-frame
        sb.push_back(8'hC3);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 0);
        pop_check("fc3");
        check("fc3_empty", out_valid, 0);
        dir = 1'b0;

        // Bad parity, then a good frame
        send_frame(8'h35, 1'b1, 1'b0, 1'b0, 0);
        check("bad_par_err", par_err, 1);
        check("bad_valid", out_valid, 0);
        tick();
        check("bad_par_err_end", par_err, 0);
        sb.push_back(8'h0F);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 0);
        check("f0f_par_err", par_err, 0);
        pop_check("f0f");

        // Backpressure: third frame overflows
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 0);
        sb.push_back(8'h22);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 0);
        check("bp2_overflow", overflow, 0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, 0);
        check("bp3_overflow", overflow, 1);
        tick();
        check("bp3_overflow_end", overflow, 0);
        check("bp_head_stable", out_data, 8'h11);
        pop_check("bp11");
        pop_check("bp22");
        check("bp_empty", out_valid, 0);

        // Buffered byte plus partial frame, then reset
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0);
        check("pre_rst_valid", out_valid, 1);
        send_bit(1'b1, 1); send_bit(1'b0, 2); send_bit(1'b1, 0); send_bit(1'b0, 1);
        send_bit(1'b1, 3); send_bit(1'b0, 0);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        enb = 1'($urandom);
        tick();
        rst = 1'b0;
        enb = 1'b0;
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", out_valid, 0);
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 3);
        pop_check("fa5");
        check("fa5_empty", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
